pmod_enc_ctrl_core: RTL

PMOD_ENC_CTRL_CORE -- requirements
Module: pmod_enc_ctrl_core

---
 rtl/pmod_enc_pkg.sv | 37 +++
 rtl/pmod_enc_ctrl_core_fifo.sv | 52 +++++
 rtl/pmod_enc_ctrl_core.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pmod_enc_pkg.sv
// Shared definitions for the rotary-encoder controller: register map, bit positions, quad states.
package pmod_enc_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STEP   = 3'd1;
  localparam logic [2:0] ADDR_MIN    = 3'd2;
  localparam logic [2:0] ADDR_MAX    = 3'd3;
  localparam logic [2:0] ADDR_POS    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_EVENT  = 3'd6;
  localparam logic [2:0] ADDR_CLEAR  = 3'd7;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_WRAP   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STAT_EMPTY = 5;
  localparam int unsigned STAT_FULL  = 6;
  localparam int unsigned STAT_OVF   = 7;
  localparam int unsigned STAT_QERR  = 8;
  localparam int unsigned STAT_BTN   = 9;

  localparam int unsigned CLR_OVF   = 0;
  localparam int unsigned CLR_QERR  = 1;
  localparam int unsigned CLR_FLUSH = 2;

  localparam int unsigned EVT_DIR = 31;
  localparam int unsigned EVT_BTN = 30;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_t;

endpackage

// File: rtl/pmod_enc_ctrl_core_fifo.sv
// Synchronous step-event FIFO with flush; a push into a full FIFO only succeeds alongside a pop.
module enc_event_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             pop_ok, push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (flush | ~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[flush ? '0 : wr_ptr] <= din;
  end

endmodule

// File: rtl/pmod_enc_ctrl_core.sv
// Quadrature encoder controller: detent decoding, clamped/wrapped position, event FIFO, register slot.
module pmod_enc_ctrl_core
  import pmod_enc_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        a_db,
  input  logic        b_db,
  input  logic        btn_db,
  output logic        irq
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [2:0] PH_POS3 = 3'sd3;
  localparam logic signed [2:0] PH_NEG3 = -3'sd3;

  quad_state_t       q_state, q_next;
  logic [1:0]        ab;
  logic              cw_move, ccw_move, illegal;
  logic signed [2:0] phase_q, phase_n;
  logic              step_q, step_n, step_dir_q, step_dir_n;

  logic [2:0]        ctrl_q;
  logic [CNT_W-1:0]  step_r, min_r, max_r, pos_q, pos_step;
  logic              ovf_q, qerr_q;
  logic [15:0]       err_cnt_q;

  logic              wr_en, pos_wr, clr_wr, step_apply, pop_req, ovf_set;
  logic [CNT_W:0]    ext;
  logic              below, above;
  logic [31:0]       evt, fifo_head, status;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_full, fifo_empty;
  logic              unused_bits;

  assign ab          = {a_db, b_db};
  assign unused_bits = &{1'b0, addr[4:3], wr_data[31:CNT_W]};

  // Quad state register: previous AB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_state    <= Q00;
      phase_q    <= '0;
      step_q     <= 1'b0;
      step_dir_q <= 1'b0;
    end else begin
      q_state    <= q_next;
      phase_q    <= phase_n;
      step_q     <= step_n;
      step_dir_q <= step_dir_n;
    end
  end

  // Transition decode and phase accumulation
  always_comb begin
    q_next     = quad_state_t'(ab);
    cw_move    = 1'b0;
    ccw_move   = 1'b0;
    illegal    = ((q_state ^ ab) == 2'b11);
    phase_n    = phase_q;
    step_n     = 1'b0;
    step_dir_n = 1'b0;
    case (q_state)
      Q00: begin cw_move = (ab == Q01); ccw_move = (ab == Q10); end
      Q01: begin cw_move = (ab == Q11); ccw_move = (ab == Q00); end
      Q11: begin cw_move = (ab == Q10); ccw_move = (ab == Q01); end
      Q10: begin cw_move = (ab == Q00); ccw_move = (ab == Q11); end
      default: ;
    endcase
    if (!ctrl_q[CTRL_EN] || illegal) begin
      phase_n = '0;
    end else if (cw_move) begin
      if (phase_q == PH_POS3) begin
        phase_n    = '0;
        step_n     = 1'b1;
        step_dir_n = 1'b1;
      end else begin
        phase_n = phase_q + 3'sd1;
      end
    end else if (ccw_move) begin
      if (phase_q == PH_NEG3) begin
        phase_n = '0;
        step_n  = 1'b1;
      end else begin
        phase_n = phase_q - 3'sd1;
      end
    end
  end

  assign wr_en      = cs & write;
  assign pos_wr     = wr_en & (addr[2:0] == ADDR_POS);
  assign clr_wr     = wr_en & (addr[2:0] == ADDR_CLEAR);
  assign pop_req    = cs & read & (addr[2:0] == ADDR_EVENT);
  assign step_apply = step_q & ctrl_q[CTRL_EN] & ~pos_wr;

  // Step arithmetic with one guard bit, then saturate or one-step wrap
  always_comb begin
    if (step_dir_q) begin
      ext   = {1'b0, pos_q} + {1'b0, step_r};
      below = (ext < {1'b0, min_r});
      above = (ext > {1'b0, max_r});
    end else begin
      ext   = {1'b0, pos_q} - {1'b0, step_r};
      below = ext[CNT_W] | (ext[CNT_W-1:0] < min_r);
      above = ~ext[CNT_W] & (ext[CNT_W-1:0] > max_r);
    end
    if (below)      pos_step = ctrl_q[CTRL_WRAP] ? max_r : min_r;
    else if (above) pos_step = ctrl_q[CTRL_WRAP] ? min_r : max_r;
    else            pos_step = ext[CNT_W-1:0];
  end

  always_comb begin
    evt                = '0;
    evt[EVT_DIR]       = step_dir_q;
    evt[EVT_BTN]       = btn_db;
    evt[CNT_W-1:0]     = pos_step;
  end

  assign ovf_set = step_apply & fifo_full & ~pop_req & ~(clr_wr & wr_data[CLR_FLUSH]);

  // Register file and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      step_r    <= CNT_W'(1);
      min_r     <= '0;
      max_r     <= '1;
      pos_q     <= '0;
      ovf_q     <= 1'b0;
      qerr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (wr_en && addr[2:0] == ADDR_CTRL) ctrl_q <= wr_data[2:0];
      if (wr_en && addr[2:0] == ADDR_STEP) step_r <= wr_data[CNT_W-1:0];
      if (wr_en && addr[2:0] == ADDR_MIN)  min_r  <= wr_data[CNT_W-1:0];
      if (wr_en && addr[2:0] == ADDR_MAX)  max_r  <= wr_data[CNT_W-1:0];
      if (pos_wr)          pos_q <= wr_data[CNT_W-1:0];
      else if (step_apply) pos_q <= pos_step;
      if (ovf_set)                         ovf_q <= 1'b1;
      else if (clr_wr && wr_data[CLR_OVF]) ovf_q <= 1'b0;
      if (illegal) begin
        qerr_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (clr_wr && wr_data[CLR_QERR]) begin
        qerr_q    <= 1'b0;
        err_cnt_q <= '0;
      end
    end
  end

  enc_event_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (step_apply),
    .pop   (pop_req),
    .flush (clr_wr & wr_data[CLR_FLUSH]),
    .din   (evt),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status             = '0;
    status[4:0]        = 5'(fifo_count);
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
    status[STAT_QERR]  = qerr_q;
    status[STAT_BTN]   = btn_db;
    status[31:16]      = err_cnt_q;
  end

  // Combinational read mux
  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      ADDR_CTRL:   rd_data = 32'(ctrl_q);
      ADDR_STEP:   rd_data = 32'(step_r);
      ADDR_MIN:    rd_data = 32'(min_r);
      ADDR_MAX:    rd_data = 32'(max_r);
      ADDR_POS:    rd_data = 32'(pos_q);
      ADDR_STATUS: rd_data = status;
      ADDR_EVENT:  rd_data = fifo_empty ? 32'd0 : fifo_head;
      default:     rd_data = '0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | ovf_q);

endmodule
